// File: rtl/riscv_imem_if.sv
// Fetch and program-load signal bundle for the instruction memory.
// master = core/loader side, slave = memory side.
interface riscv_imem_if #(
    parameter int ADDR_W = 8
);
    logic              fetchReq;
    logic [ADDR_W-1:0] fetchAddr;
    logic              fetchValid;
    logic [31:0]       fetchInstr;
    logic              loadEn;
    logic              loadByteValid;
    logic [7:0]        loadByte;
    logic              loadBusy;
    logic [ADDR_W:0]   loadCount;
    logic              loadDone;

    modport master (
        output fetchReq, fetchAddr, loadEn, loadByteValid, loadByte,
        input  fetchValid, fetchInstr, loadBusy, loadCount, loadDone
    );

    modport slave (
        input  fetchReq, fetchAddr, loadEn, loadByteValid, loadByte,
        output fetchValid, fetchInstr, loadBusy, loadCount, loadDone
    );
endinterface

// File: rtl/riscv_imem.sv
// Instruction memory with a byte-stream program loader (little-endian word assembly).
// Latency: fetch data one cycle after the request; each loaded byte is absorbed in its own cycle.
// Backpressure: none; fetches are ignored while loading and bytes are dropped once memory is full.
module riscv_imem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input logic         clk,
    input logic         rstN,
    riscv_imem_if.slave bus
);
    typedef enum logic [1:0] {RUN, LOAD, FULL, FLUSH} state_e;

    state_e              state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
    logic [ADDR_W:0]     load_count_q, load_count_d;
    logic [31:0]         asm_word_q, asm_word_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic [31:0]         fetch_instr_q, fetch_instr_d;
    logic                load_done_q, load_done_d;

    logic                mem_we;
    logic [31:0]         mem_wdata;
    logic [31:0]         asm_merged;
    logic [31:0]         mem [DEPTH];

    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        write_addr_d  = write_addr_q;
        load_count_d  = load_count_q;
        asm_word_d    = asm_word_q;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        load_done_d   = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = asm_word_q;

        // Unwritten byte lanes stay zero, so a flushed partial word is already padded.
        asm_merged = asm_word_q;
        asm_merged[{byte_idx_q, 3'b000} +: 8] = bus.loadByte;

        unique case (state_q)
            RUN: begin
                if (bus.loadEn) begin
                    state_d      = LOAD;
                    byte_idx_d   = 2'd0;
                    write_addr_d = '0;
                    load_count_d = '0;
                    asm_word_d   = '0;
                end else begin
                    fetch_valid_d = bus.fetchReq;
                    if (bus.fetchReq) begin
                        fetch_instr_d = mem[bus.fetchAddr];
                    end
                end
            end
            LOAD: begin
                if (!bus.loadEn) begin
                    if (byte_idx_q == 2'd0) begin
                        state_d     = RUN;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = FLUSH;
                    end
                end else if (bus.loadByteValid) begin
                    if (byte_idx_q == 2'd3) begin
                        mem_we       = 1'b1;
                        mem_wdata    = asm_merged;
                        asm_word_d   = '0;
                        byte_idx_d   = 2'd0;
                        load_count_d = load_count_q + 1'b1;
                        // Last slot written: park the address rather than wrap onto word 0.
                        if (write_addr_q == ADDR_W'(DEPTH - 1)) begin
                            state_d = FULL;
                        end else begin
                            write_addr_d = write_addr_q + 1'b1;
                        end
                    end else begin
                        asm_word_d = asm_merged;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            FULL: begin
                if (!bus.loadEn) begin
                    state_d     = RUN;
                    load_done_d = 1'b1;
                end
            end
            FLUSH: begin
                mem_we       = 1'b1;
                mem_wdata    = asm_word_q;
                asm_word_d   = '0;
                byte_idx_d   = 2'd0;
                load_count_d = load_count_q + 1'b1;
                state_d      = RUN;
                load_done_d  = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= RUN;
            byte_idx_q    <= 2'd0;
            write_addr_q  <= '0;
            load_count_q  <= '0;
            asm_word_q    <= '0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
            load_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            write_addr_q  <= write_addr_d;
            load_count_q  <= load_count_d;
            asm_word_q    <= asm_word_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            load_done_q   <= load_done_d;
        end
    end

    // Storage is deliberately outside the reset domain so a program survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[write_addr_q] <= mem_wdata;
        end
    end

    assign bus.fetchValid = fetch_valid_q;
    assign bus.fetchInstr = fetch_instr_q;
    assign bus.loadBusy   = (state_q != RUN);
    assign bus.loadCount  = load_count_q;
    assign bus.loadDone   = load_done_q;
endmodule

// File: tb/tb_riscv_imem.sv
// Directed bench for riscv_imem: fetch latency, word assembly, flush, full, reset behaviour.
module tb_riscv_imem;
    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   errors = 0;
    int   checks = 0;

    riscv_imem_if #(.ADDR_W(8)) bus ();

    riscv_imem #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.fetchReq = 0; bus.fetchAddr = '0; bus.loadEn = 0;
        bus.loadByteValid = 0; bus.loadByte = '0;
        rstN = 0;
        tick(); tick();
        checks++; if (bus.fetchValid !== 1'b0) begin errors++; $display("FAIL rst_fetchValid got=%h exp=0", bus.fetchValid); end
        checks++; if (bus.fetchInstr !== 32'h0) begin errors++; $display("FAIL rst_fetchInstr got=%h exp=0", bus.fetchInstr); end
        checks++; if (bus.loadBusy !== 1'b0) begin errors++; $display("FAIL rst_loadBusy got=%h exp=0", bus.loadBusy); end
        checks++; if (bus.loadCount !== 9'd0) begin errors++; $display("FAIL rst_loadCount got=%0d exp=0", bus.loadCount); end
        checks++; if (bus.loadDone !== 1'b0) begin errors++; $display("FAIL rst_loadDone got=%h exp=0", bus.loadDone); end
        rstN = 1;
        tick();
    endtask

    task automatic test_load_basic();
        logic [7:0] b [8];
        b = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        bus.loadEn = 1;
        tick();
        checks++; if (bus.loadBusy !== 1'b1) begin errors++; $display("FAIL load_busy got=%h exp=1", bus.loadBusy); end
        for (int i = 0; i < 8; i++) begin
            bus.loadByteValid = 1; bus.loadByte = b[i];
            tick();
        end
        bus.loadByteValid = 0;
        checks++; if (bus.loadCount !== 9'd2) begin errors++; $display("FAIL load_count got=%0d exp=2", bus.loadCount); end
        checks++; if (bus.loadDone !== 1'b0) begin errors++; $display("FAIL load_done_early got=%h exp=0", bus.loadDone); end
        bus.loadEn = 0;
        tick();
        checks++; if (bus.loadDone !== 1'b1) begin errors++; $display("FAIL load_done_pulse got=%h exp=1", bus.loadDone); end
        checks++; if (bus.loadBusy !== 1'b0) begin errors++; $display("FAIL load_idle got=%h exp=0", bus.loadBusy); end
        tick();
        checks++; if (bus.loadDone !== 1'b0) begin errors++; $display("FAIL load_done_once got=%h exp=0", bus.loadDone); end
        checks++; if (bus.loadCount !== 9'd2) begin errors++; $display("FAIL load_count_hold got=%0d exp=2", bus.loadCount); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a [3];
        logic [31:0] e [3];
        a = '{8'd0, 8'd1, 8'd0};
        e = '{32'h00500013, 32'h00100093, 32'h00500013};
        for (int i = 0; i < 3; i++) begin
            bus.fetchReq = 1; bus.fetchAddr = a[i];
            tick();
            checks++; if (bus.fetchValid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got=%h exp=1", i, bus.fetchValid); end
            checks++; if (bus.fetchInstr !== e[i]) begin errors++; $display("FAIL b2b_instr%0d got=%h exp=%h", i, bus.fetchInstr, e[i]); end
        end
        bus.fetchReq = 0; bus.fetchAddr = 8'd1;
        tick();
        checks++; if (bus.fetchValid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%h exp=0", bus.fetchValid); end
        checks++; if (bus.fetchInstr !== 32'h00500013) begin errors++; $display("FAIL idle_hold got=%h exp=00500013", bus.fetchInstr); end
    endtask

    task automatic test_flush();
        logic [7:0] b [6];
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        bus.loadEn = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.loadByteValid = 1; bus.loadByte = b[i];
            tick();
        end
        checks++; if (bus.loadCount !== 9'd1) begin errors++; $display("FAIL flush_pre_count got=%0d exp=1", bus.loadCount); end
        // Byte offered in the same cycle loadEn drops must be discarded.
        bus.loadByte = 8'h77; bus.loadEn = 0;
        tick();
        bus.loadByteValid = 0;
        checks++; if (bus.loadBusy !== 1'b1) begin errors++; $display("FAIL flush_busy got=%h exp=1", bus.loadBusy); end
        checks++; if (bus.loadDone !== 1'b0) begin errors++; $display("FAIL flush_done_early got=%h exp=0", bus.loadDone); end
        tick();
        checks++; if (bus.loadDone !== 1'b1) begin errors++; $display("FAIL flush_done got=%h exp=1", bus.loadDone); end
        checks++; if (bus.loadCount !== 9'd2) begin errors++; $display("FAIL flush_count got=%0d exp=2", bus.loadCount); end
        bus.fetchReq = 1; bus.fetchAddr = 8'd0;
        tick();
        checks++; if (bus.fetchInstr !== 32'h44332211) begin errors++; $display("FAIL flush_mem0 got=%h exp=44332211", bus.fetchInstr); end
        bus.fetchAddr = 8'd1;
        tick();
        checks++; if (bus.fetchInstr !== 32'h00006655) begin errors++; $display("FAIL flush_mem1 got=%h exp=00006655", bus.fetchInstr); end
        bus.fetchReq = 0;
        tick();
    endtask

    task automatic test_reload_on_done();
        logic [7:0] b [4];
        b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        bus.loadEn = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.loadByteValid = 1; bus.loadByte = b[i];
            tick();
        end
        bus.loadByteValid = 0; bus.loadEn = 0;
        tick();
        checks++; if (bus.loadDone !== 1'b1) begin errors++; $display("FAIL reload_done got=%h exp=1", bus.loadDone); end
        bus.loadEn = 1;
        tick();
        checks++; if (bus.loadBusy !== 1'b1) begin errors++; $display("FAIL reload_busy got=%h exp=1", bus.loadBusy); end
        checks++; if (bus.loadCount !== 9'd0) begin errors++; $display("FAIL reload_count got=%0d exp=0", bus.loadCount); end
        bus.loadEn = 0;
        tick();
        bus.fetchReq = 1; bus.fetchAddr = 8'd0;
        tick();
        checks++; if (bus.fetchInstr !== 32'hDDCCBBAA) begin errors++; $display("FAIL reload_mem0 got=%h exp=ddccbbaa", bus.fetchInstr); end
        bus.fetchReq = 0;
        tick();
    endtask

    task automatic test_full();
        bus.loadEn = 1;
        tick();
        for (int i = 0; i < 1028; i++) begin
            bus.loadByteValid = 1;
            bus.loadByte = (i < 1024) ? 8'(i) : 8'hEE;
            tick();
            if (i == 1022) begin
                checks++; if (bus.loadCount !== 9'd255) begin errors++; $display("FAIL full_count255 got=%0d exp=255", bus.loadCount); end
            end
            if (i == 1023) begin
                checks++; if (bus.loadCount !== 9'd256) begin errors++; $display("FAIL full_count256 got=%0d exp=256", bus.loadCount); end
            end
        end
        bus.loadByteValid = 0;
        checks++; if (bus.loadCount !== 9'd256) begin errors++; $display("FAIL full_count_drop got=%0d exp=256", bus.loadCount); end
        checks++; if (bus.loadBusy !== 1'b1) begin errors++; $display("FAIL full_busy got=%h exp=1", bus.loadBusy); end
        bus.loadEn = 0;
        tick();
        checks++; if (bus.loadDone !== 1'b1) begin errors++; $display("FAIL full_done got=%h exp=1", bus.loadDone); end
        bus.fetchReq = 1; bus.fetchAddr = 8'd0;
        tick();
        checks++; if (bus.fetchInstr !== 32'h03020100) begin errors++; $display("FAIL full_mem0 got=%h exp=03020100", bus.fetchInstr); end
        bus.fetchAddr = 8'd255;
        tick();
        checks++; if (bus.fetchInstr !== 32'hFFFEFDFC) begin errors++; $display("FAIL full_mem255 got=%h exp=fffefdfc", bus.fetchInstr); end
        bus.fetchReq = 0;
        tick();
    endtask

    task automatic test_fetch_vs_load();
        bus.fetchReq = 1; bus.fetchAddr = 8'd0; bus.loadEn = 1;
        tick();
        checks++; if (bus.fetchValid !== 1'b0) begin errors++; $display("FAIL collide_valid got=%h exp=0", bus.fetchValid); end
        checks++; if (bus.loadBusy !== 1'b1) begin errors++; $display("FAIL collide_busy got=%h exp=1", bus.loadBusy); end
        tick();
        checks++; if (bus.fetchValid !== 1'b0) begin errors++; $display("FAIL collide_load_valid got=%h exp=0", bus.fetchValid); end
        bus.fetchReq = 0; bus.loadEn = 0;
        tick();
        checks++; if (bus.loadDone !== 1'b1) begin errors++; $display("FAIL collide_done got=%h exp=1", bus.loadDone); end
    endtask

    task automatic test_reset_mid_load();
        bus.loadEn = 1;
        tick();
        bus.loadByteValid = 1; bus.loadByte = 8'h55;
        tick();
        bus.loadByte = 8'h66;
        tick();
        bus.loadByteValid = 0; bus.loadEn = 0;
        rstN = 0;
        #1;
        checks++; if (bus.fetchValid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%h exp=0", bus.fetchValid); end
        checks++; if (bus.fetchInstr !== 32'h0) begin errors++; $display("FAIL mid_rst_instr got=%h exp=0", bus.fetchInstr); end
        checks++; if (bus.loadBusy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%h exp=0", bus.loadBusy); end
        checks++; if (bus.loadCount !== 9'd0) begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", bus.loadCount); end
        checks++; if (bus.loadDone !== 1'b0) begin errors++; $display("FAIL mid_rst_done got=%h exp=0", bus.loadDone); end
        tick();
        rstN = 1; bus.fetchReq = 1; bus.fetchAddr = 8'd0;
        tick();
        checks++; if (bus.fetchValid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got=%h exp=1", bus.fetchValid); end
        checks++; if (bus.fetchInstr !== 32'h03020100) begin errors++; $display("FAIL post_rst_mem0 got=%h exp=03020100", bus.fetchInstr); end
        bus.fetchAddr = 8'd1;
        tick();
        checks++; if (bus.fetchInstr !== 32'h07060504) begin errors++; $display("FAIL post_rst_mem1 got=%h exp=07060504", bus.fetchInstr); end
        bus.fetchReq = 0; bus.loadEn = 1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            bus.loadByteValid = 1; bus.loadByte = 8'(i);
            tick();
        end
        bus.loadByteValid = 0; bus.loadEn = 0;
        tick();
        bus.fetchReq = 1; bus.fetchAddr = 8'd0;
        tick();
        checks++; if (bus.fetchInstr !== 32'h04030201) begin errors++; $display("FAIL reload_after_rst got=%h exp=04030201", bus.fetchInstr); end
        bus.fetchReq = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_back_to_back();
        test_flush();
        test_reload_on_done();
        test_full();
        test_fetch_vs_load();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_imem.md
RISCV_IMEM -- requirements
Module: riscv_imem

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit instruction words.
REQ-002 Parameter ADDR_W, default 8, word-address width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstN  input  1  asynchronous, active-low reset.
REQ-005 fetchReq  input  1  fetch request; address sampled this cycle.
REQ-006 fetchAddr  input  ADDR_W  instruction word address (driven by the program counter).
REQ-007 fetchValid  output  1  fetchInstr holds the word for the previous cycle's request.
REQ-008 fetchInstr  output  32  instruction word.
REQ-009 loadEn  input  1  level; high selects program-load mode.
REQ-010 loadByteValid  input  1  loadByte valid this cycle.
REQ-011 loadByte  input  8  program byte, little-endian stream.
REQ-012 loadBusy  output  1  high while state is not RUN.
REQ-013 loadCount  output  ADDR_W+1  words written since load start.
REQ-014 loadDone  output  1  one-cycle pulse on return to RUN after a load.

Function
REQ-015 FSM states SHALL be RUN, LOAD, FULL and FLUSH.
REQ-016 RUN: fetchReq=1 at edge N SHALL give fetchValid=1 and fetchInstr=mem[fetchAddr sampled at N] after edge N (1-cycle latency); back-to-back requests SHALL each be served at one per cycle.
REQ-017 RUN: fetchReq=0 SHALL give fetchValid=0 next cycle while fetchInstr holds its last value.
REQ-018 RUN with loadEn=1 SHALL enter LOAD and clear byteIdx, writeAddr and loadCount; loadEn wins over a simultaneous fetchReq, which is dropped (fetchValid=0 next cycle).
REQ-019 LOAD/FULL/FLUSH: fetchReq ignored; fetchValid SHALL be 0.
REQ-020 LOAD: each loadByteValid byte SHALL be placed at bits [8*byteIdx+7:8*byteIdx] of the assembly word, and byteIdx SHALL increment modulo 4.
REQ-021 The 4th byte SHALL write the completed word to mem[writeAddr] in that same cycle, then increment writeAddr and loadCount.
REQ-022 A write at writeAddr=DEPTH-1 SHALL leave loadCount=DEPTH and move to FULL; writeAddr SHALL NOT wrap.
REQ-023 FULL: bytes SHALL be dropped until loadEn=0, then go to RUN.
REQ-024 LOAD with loadEn=0 and byteIdx=0 SHALL go to RUN.
REQ-025 LOAD with loadEn=0 and byteIdx!=0 SHALL go to FLUSH, dropping any byte presented in that cycle.
REQ-026 FLUSH SHALL take one cycle, write the partial word zero-padded in its upper bytes, increment loadCount, then go to RUN.
REQ-027 loadDone SHALL pulse for exactly one cycle, coincident with the first RUN cycle after LOAD, FLUSH or FULL.
REQ-028 loadCount SHALL hold its value in RUN until the next load starts.
REQ-029 loadEn re-asserted in the loadDone cycle SHALL start a new load, restarting loadCount at 0.

Reset
REQ-030 rstN=0 SHALL immediately force state=RUN, fetchValid=0, fetchInstr=0, loadBusy=0, loadCount=0, loadDone=0, byteIdx=0, writeAddr=0.
REQ-031 Reset SHALL NOT clear memory contents; a partial word pending at reset SHALL be discarded, not written.
REQ-032 Release of rstN SHALL require no extra cycles: a fetchReq at the first edge after release SHALL be served.

Verification
REQ-033 Load bytes 13,00,50,00 then 93,00,10,00, drop loadEn -> mem[0]=0x00500013, mem[1]=0x00100093, loadCount=2, loadDone pulses once, no FLUSH.
REQ-034 After REQ-033, fetchReq=1 with fetchAddr 0,1,0 on consecutive cycles -> fetchValid=1 for 3 cycles, fetchInstr=0x00500013, 0x00100093, 0x00500013.
REQ-035 Load 6 bytes 11,22,33,44,55,66, drop loadEn -> mem[0]=0x44332211, one FLUSH cycle, mem[1]=0x00006655, loadCount=2.
REQ-036 Stream 1028 bytes -> loadCount=256 and state FULL after byte 1024; last 4 bytes dropped; mem[0] not overwritten.
REQ-037 fetchReq and loadEn rise together -> fetchValid=0 next cycle, loadBusy=1.
REQ-038 Assert rstN=0 after 2 of 4 bytes, then reload and fetch address 0 -> previous mem[0] unchanged, all outputs at reset values during reset.
